avm_multi_master_arbiter: RTL and testbench
===========================================

# avm_multi_master_arbiter

Parametrised successor to the accelerator's single-port Avalon-MM master bridge. It accepts NUM_CH independent accelerator request ports (Sobel/magnitude/threshold engines) and arbitrates them round-robin onto one Avalon-MM master port toward the SDRAM interconnect. Commands are registered, and each slave `waitrequest` stall is absorbed internally. Read data and completion are returned per channel, so engines no longer need exclusive bus ownership.

## Interface
- NUM_CH, 4: number of accelerator channels (1..8).
- DATA_WIDTH, 8: data width, channel side and bus side.
- CH_ADDR_WIDTH, 18: channel address width; must be ≤ ADDR_WIDTH.
- ADDR_WIDTH, 32: Avalon address width.
- CH_STRIDE, 32'h0004_0000: byte offset added per channel index.

- CSI_CLOCK_CLK  in  1  sole clock; all logic on rising edge.
- CSI_CLOCK_RESET  in  1  reset, synchronous, active-high.
- ch_address  in  NUM_CH*CH_ADDR_WIDTH  per-channel address; channel i at slice i.
- ch_writedata  in  NUM_CH*DATA_WIDTH  per-channel write data.
- ch_read  in  NUM_CH  per-channel read request.
- ch_write  in  NUM_CH  per-channel write request.
- ch_waitrequest  out  NUM_CH  per-channel stall; low for exactly one cycle when the request completes.
- ch_readdata  out  DATA_WIDTH  shared read-data return; valid only with ch_readdatavalid.
- ch_readdatavalid  out  NUM_CH  one-hot, one-cycle read-completion strobe.
- AVM_AVALONMASTER_ADDRESS  out  ADDR_WIDTH  bus address.
- AVM_AVALONMASTER_READ  out  1  bus read.
- AVM_AVALONMASTER_WRITE  out  1  bus write.
- AVM_AVALONMASTER_WRITEDATA  out  DATA_WIDTH  bus write data.
- AVM_AVALONMASTER_READDATA  in  DATA_WIDTH  bus read data; sampled when waitrequest is low during a read.
- AVM_AVALONMASTER_WAITREQUEST  in  1  slave stall.

## Operation
- Channel request: req[i] = ch_read[i] | ch_write[i].
  - The channel holds its request and operands until ch_waitrequest[i] is sampled low.
  - If read and write are both high, the write is performed and the read is ignored.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if any req, grant the first requesting channel after last_grant (wrapping NUM_CH-1 → 0). Latch op, data and address into registers, then go to ISSUE. With no request, stay in IDLE.
  - ISSUE: drive the registered command on AVM_*. If AVALONMASTER_WAITREQUEST is low, capture READDATA (reads only) and go to RESP. Otherwise hold all AVM outputs stable and stay in ISSUE.
  - RESP: drive ch_waitrequest[grant]=0. For a read, also drive ch_readdatavalid[grant]=1 and present the captured data on ch_readdata. Set last_grant=grant and return to IDLE.
- Bus address = zero_extend(ch_address[grant]) + grant*CH_STRIDE, truncated modulo 2^ADDR_WIDTH.
- AVM_READ and AVM_WRITE are never high together and are high only in ISSUE.
- ch_waitrequest[i] is high in every cycle except RESP of channel i. A requesting channel is therefore always stalled until it is served.
- A channel that drops its request mid-transaction is still completed; a request sampled in IDLE is committed.

## Timing
- Reset values:
  - state=IDLE, last_grant=NUM_CH-1 (channel 0 is served first).
  - AVM_ADDRESS=0, AVM_READ=0, AVM_WRITE=0, AVM_WRITEDATA=0.
  - ch_waitrequest=all ones, ch_readdatavalid=0, ch_readdata=0.
- Reset mid-transaction: AVM_READ/WRITE deassert at the reset edge, the transaction is abandoned, and no channel is acknowledged.
- Latency:
  - Request sampled in IDLE at cycle 0.
  - AVM command asserted in cycle 1.
  - With zero slave wait states, channel ack and readdata valid in cycle 2.
  - Each slave wait-state cycle adds one cycle.
- Throughput: one transaction per 3 cycles minimum.
- Fairness: no channel waits more than NUM_CH-1 other transactions once its request is asserted.

## Structure
- Package avm_arb_pkg: state enum (IDLE/ISSUE/RESP), a function computing the bus address from (addr, index, stride).
- Sub-module rr_arbiter (NUM_CH): inputs req vector and last_grant; outputs one-hot grant and its index. Purely combinational.
- Top level: FSM, command and readdata registers, output decode.

## Test plan
- Single read: ch1 reads addr 18'h00010, slave WAITREQUEST low → AVM_ADDRESS=32'h0004_0010 in cycle 1; ch_readdatavalid=4'b0010 and ch_readdata=slave data 8'hA5 in cycle 2.
- Write with 3 wait states: ch0 writes 8'h3C to 18'h0 → AVM_WRITE held high with stable address/data for 4 cycles; ch_waitrequest[0] low once, the cycle after WAITREQUEST falls.
- All four channels request at once, right after reset → grants in order 0,1,2,3, each acked exactly once, no overlap on AVM_READ/WRITE.
- ch2 requests continuously while ch3 also requests → service alternates 2,3,2,3.
- Read and write asserted together on ch0 → a single write is issued, no readdatavalid.
- Reset asserted in ISSUE with slave stalling → AVM_READ low next cycle, ch_waitrequest all ones; after reset, channel 0 is granted first.

Source files
------------

// File: rtl/avm_arb_pkg.sv
// Shared types and helpers for the multi-master Avalon-MM arbiter.
//   arb_state_t : transaction sequencer states (IDLE -> ISSUE -> RESP).
//   bus_address : maps a channel-local address onto the shared bus window
//                 of that channel (addr + index * stride). The math is done
//                 at 64 bits; the caller truncates to its own bus width.
package avm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  function automatic logic [63:0] bus_address(input logic [63:0] addr,
                                              input logic [63:0] index,
                                              input logic [63:0] stride);
    return addr + index * stride;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per channel.
//   last_grant : index of the channel served most recently.
//   grant      : one-hot winner (all zero when nothing requests).
//   grant_idx  : binary index of the winner (0 when nothing requests).
// The search starts at last_grant+1 and wraps, so the most recently served
// channel has the lowest priority.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_CH);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/avm_multi_master_arbiter.sv
// Round-robin arbiter placing NUM_CH accelerator request ports onto a single
// Avalon-MM master port. One transaction is in flight at a time:
//   IDLE  : pick the next requester, register its command.
//   ISSUE : drive the registered command until the slave drops waitrequest.
//   RESP  : acknowledge the channel for one cycle (plus read data).
// Ports:
//   CSI_CLOCK_CLK / CSI_CLOCK_RESET      : clock, sync active-high reset.
//   ch_address/ch_writedata/ch_read/ch_write : packed per-channel requests.
//   ch_waitrequest  : per-channel stall, low only in that channel's RESP.
//   ch_readdata     : shared read return, qualified by ch_readdatavalid.
//   ch_readdatavalid: one-hot read completion strobe.
//   AVM_AVALONMASTER_* : the shared Avalon-MM master port.
module avm_multi_master_arbiter
  import avm_arb_pkg::*;
#(
  parameter int          NUM_CH        = 4,
  parameter int          DATA_WIDTH    = 8,
  parameter int          CH_ADDR_WIDTH = 18,
  parameter int          ADDR_WIDTH    = 32,
  parameter logic [31:0] CH_STRIDE     = 32'h0004_0000
) (
  input  logic                              CSI_CLOCK_CLK,
  input  logic                              CSI_CLOCK_RESET,
  input  logic [NUM_CH*CH_ADDR_WIDTH-1:0]   ch_address,
  input  logic [NUM_CH*DATA_WIDTH-1:0]      ch_writedata,
  input  logic [NUM_CH-1:0]                 ch_read,
  input  logic [NUM_CH-1:0]                 ch_write,
  output logic [NUM_CH-1:0]                 ch_waitrequest,
  output logic [DATA_WIDTH-1:0]             ch_readdata,
  output logic [NUM_CH-1:0]                 ch_readdatavalid,
  output logic [ADDR_WIDTH-1:0]             AVM_AVALONMASTER_ADDRESS,
  output logic                              AVM_AVALONMASTER_READ,
  output logic                              AVM_AVALONMASTER_WRITE,
  output logic [DATA_WIDTH-1:0]             AVM_AVALONMASTER_WRITEDATA,
  input  logic [DATA_WIDTH-1:0]             AVM_AVALONMASTER_READDATA,
  input  logic                              AVM_AVALONMASTER_WAITREQUEST
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arb_state_t              state, state_next;
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH-1:0]       grant_oh;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        last_grant;
  logic [63:0]             addr_ext;
  logic [ADDR_WIDTH-1:0]   addr_bus;

  logic [IDX_W-1:0]        grant_p1;
  logic                    op_write_p1;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic [DATA_WIDTH-1:0]   wdata_p1;
  logic [DATA_WIDTH-1:0]   rdata_p2;

  assign req = ch_read | ch_write;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant_oh),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    addr_ext = '0;
    addr_ext[CH_ADDR_WIDTH-1:0] = ch_address[grant_idx*CH_ADDR_WIDTH +: CH_ADDR_WIDTH];
    addr_bus = ADDR_WIDTH'(bus_address(addr_ext, 64'(grant_idx), 64'(CH_STRIDE)));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = ISSUE;
      ISSUE:   if (!AVM_AVALONMASTER_WAITREQUEST) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage p1: command captured in IDLE; write wins when read is also high.
  // Stage p2: read data captured on the cycle the slave accepts the read.
  always_ff @(posedge CSI_CLOCK_CLK) begin
    if (CSI_CLOCK_RESET) begin
      state       <= IDLE;
      last_grant  <= IDX_W'(NUM_CH - 1);
      grant_p1    <= '0;
      op_write_p1 <= 1'b0;
      addr_p1     <= '0;
      wdata_p1    <= '0;
      rdata_p2    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && |req) begin
        grant_p1    <= grant_idx;
        op_write_p1 <= |(ch_write & grant_oh);
        addr_p1     <= addr_bus;
        wdata_p1    <= ch_writedata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      end
      if (state == ISSUE && !AVM_AVALONMASTER_WAITREQUEST && !op_write_p1) begin
        rdata_p2 <= AVM_AVALONMASTER_READDATA;
      end
      if (state == RESP) begin
        last_grant <= grant_p1;
      end
    end
  end

  // Output decode: command only in ISSUE, acknowledge only in RESP.
  assign AVM_AVALONMASTER_ADDRESS   = addr_p1;
  assign AVM_AVALONMASTER_WRITEDATA = wdata_p1;
  assign AVM_AVALONMASTER_READ      = (state == ISSUE) && !op_write_p1;
  assign AVM_AVALONMASTER_WRITE     = (state == ISSUE) && op_write_p1;
  assign ch_readdata                = rdata_p2;

  always_comb begin
    ch_waitrequest   = '1;
    ch_readdatavalid = '0;
    if (state == RESP) begin
      ch_waitrequest[grant_p1] = 1'b0;
      if (!op_write_p1) ch_readdatavalid[grant_p1] = 1'b1;
    end
  end

endmodule

// File: tb/tb_avm_multi_master_arbiter.sv
// Self-checking bench for avm_multi_master_arbiter: directed scenarios plus a
// randomized run, all checked against a transaction-level reference model.
module tb_avm_multi_master_arbiter;

  localparam int          NCH    = 4;
  localparam int          DW     = 8;
  localparam int          CAW    = 18;
  localparam int          AW     = 32;
  localparam logic [31:0] STRIDE = 32'h0004_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NCH*CAW-1:0]   ch_address;
  logic [NCH*DW-1:0]    ch_writedata;
  logic [NCH-1:0]       ch_read, ch_write, ch_waitrequest, ch_readdatavalid;
  logic [DW-1:0]        ch_readdata;
  logic [AW-1:0]        avm_address;
  logic                 avm_read, avm_write, avm_waitrequest;
  logic [DW-1:0]        avm_writedata, avm_readdata;

  logic [CAW-1:0]       c_addr [NCH];
  logic [DW-1:0]        c_data [NCH];

  always_comb begin
    ch_address   = '0;
    ch_writedata = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_address[i*CAW +: CAW] = c_addr[i];
      ch_writedata[i*DW +: DW] = c_data[i];
    end
  end

  avm_multi_master_arbiter #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .CH_ADDR_WIDTH(CAW), .ADDR_WIDTH(AW), .CH_STRIDE(STRIDE)
  ) dut (
    .CSI_CLOCK_CLK                (clk),
    .CSI_CLOCK_RESET              (rst),
    .ch_address                   (ch_address),
    .ch_writedata                 (ch_writedata),
    .ch_read                      (ch_read),
    .ch_write                     (ch_write),
    .ch_waitrequest               (ch_waitrequest),
    .ch_readdata                  (ch_readdata),
    .ch_readdatavalid             (ch_readdatavalid),
    .AVM_AVALONMASTER_ADDRESS     (avm_address),
    .AVM_AVALONMASTER_READ        (avm_read),
    .AVM_AVALONMASTER_WRITE       (avm_write),
    .AVM_AVALONMASTER_WRITEDATA   (avm_writedata),
    .AVM_AVALONMASTER_READDATA    (avm_readdata),
    .AVM_AVALONMASTER_WAITREQUEST (avm_waitrequest)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: phase 0 = arbiter free, 1 = command on bus, 2 = ack cycle.
  int          m_phase, m_g, m_last, drop_g;
  logic        m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_cap;
  int          wait_cnt [NCH];
  int          served [$];

  function automatic int rr_pick(input logic [NCH-1:0] r, input int last);
    for (int k = 1; k <= NCH; k++) begin
      if (r[(last + k) % NCH]) return (last + k) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int ch, input logic [CAW-1:0] a);
    return AW'(a) + AW'(ch) * STRIDE;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_last  = NCH - 1;
    drop_g  = -1;
    for (int i = 0; i < NCH; i++) wait_cnt[i] = 0;
  endtask

  // One clock cycle: check outputs at the falling edge against the model,
  // advance the model, then after the rising edge let a completed channel
  // release its request.
  task automatic step();
    logic [NCH-1:0] exp_wrq, exp_rdv;
    logic [NCH-1:0] r;
    int g;
    @(negedge clk);
    exp_wrq = '1;
    exp_rdv = '0;
    if (m_phase == 2) begin
      exp_wrq[m_g] = 1'b0;
      if (!m_wr) exp_rdv[m_g] = 1'b1;
    end
    tests++;
    if (ch_waitrequest !== exp_wrq) begin
      fails++; $display("FAIL ch_waitrequest got=%b exp=%b t=%0t", ch_waitrequest, exp_wrq, $time);
    end
    tests++;
    if (ch_readdatavalid !== exp_rdv) begin
      fails++; $display("FAIL ch_readdatavalid got=%b exp=%b t=%0t", ch_readdatavalid, exp_rdv, $time);
    end
    if (exp_rdv != 0) begin
      tests++;
      if (ch_readdata !== m_cap) begin
        fails++; $display("FAIL ch_readdata got=%h exp=%h t=%0t", ch_readdata, m_cap, $time);
      end
    end
    tests++;
    if (avm_read !== (m_phase == 1 && !m_wr) || avm_write !== (m_phase == 1 && m_wr)) begin
      fails++; $display("FAIL avm_rw got=%b%b exp=%b%b t=%0t", avm_read, avm_write,
                        (m_phase == 1 && !m_wr), (m_phase == 1 && m_wr), $time);
    end
    if (m_phase == 1) begin
      tests++;
      if (avm_address !== m_addr) begin
        fails++; $display("FAIL avm_address got=%h exp=%h t=%0t", avm_address, m_addr, $time);
      end
      if (m_wr) begin
        tests++;
        if (avm_writedata !== m_data) begin
          fails++; $display("FAIL avm_writedata got=%h exp=%h t=%0t", avm_writedata, m_data, $time);
        end
      end
    end
    if (rst) begin
      model_reset();
    end else begin
      case (m_phase)
        0: begin
          r = ch_read | ch_write;
          if (r != 0) begin
            g      = rr_pick(r, m_last);
            m_g    = g;
            m_wr   = ch_write[g];
            m_addr = exp_addr(g, c_addr[g]);
            m_data = c_data[g];
            for (int i = 0; i < NCH; i++) begin
              if (i != g && r[i]) begin
                wait_cnt[i]++;
                tests++;
                if (wait_cnt[i] > NCH - 1) begin
                  fails++; $display("FAIL fairness ch%0d waited=%0d max=%0d", i, wait_cnt[i], NCH - 1);
                end
              end
            end
            wait_cnt[g] = 0;
            m_phase = 1;
          end
        end
        1: if (!avm_waitrequest) begin
          m_cap   = avm_readdata;
          m_phase = 2;
        end
        default: begin
          m_last  = m_g;
          served.push_back(m_g);
          drop_g  = m_g;
          m_phase = 0;
        end
      endcase
    end
    @(posedge clk);
    #1;
    if (drop_g >= 0) begin
      ch_read[drop_g]  = 1'b0;
      ch_write[drop_g] = 1'b0;
      drop_g = -1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (avm_address !== '0) begin fails++; $display("FAIL rst_address got=%h exp=0", avm_address); end
    tests++; if (avm_read !== 1'b0 || avm_write !== 1'b0) begin fails++; $display("FAIL rst_rw got=%b%b exp=00", avm_read, avm_write); end
    tests++; if (avm_writedata !== '0) begin fails++; $display("FAIL rst_wdata got=%h exp=0", avm_writedata); end
    tests++; if (ch_waitrequest !== '1) begin fails++; $display("FAIL rst_waitreq got=%b exp=1111", ch_waitrequest); end
    tests++; if (ch_readdatavalid !== '0) begin fails++; $display("FAIL rst_rdv got=%b exp=0000", ch_readdatavalid); end
    tests++; if (ch_readdata !== '0) begin fails++; $display("FAIL rst_rdata got=%h exp=0", ch_readdata); end
    rst = 1'b0;
    model_reset();
    repeat (2) step();
  endtask

  task automatic test_single_read();
    c_addr[1] = 18'h00010;
    avm_waitrequest = 1'b0;
    avm_readdata = 8'hA5;
    ch_read[1] = 1'b1;
    step();
    tests++; if (avm_address !== 32'h0004_0010) begin fails++; $display("FAIL sr_address got=%h exp=00040010", avm_address); end
    tests++; if (avm_read !== 1'b1) begin fails++; $display("FAIL sr_read got=%b exp=1", avm_read); end
    step();
    tests++; if (ch_readdatavalid !== 4'b0010) begin fails++; $display("FAIL sr_rdv got=%b exp=0010", ch_readdatavalid); end
    tests++; if (ch_readdata !== 8'hA5) begin fails++; $display("FAIL sr_rdata got=%h exp=a5", ch_readdata); end
    step();
  endtask

  task automatic test_write_wait();
    int wcnt = 0, acks = 0, ack_cyc = -1, last_w = -1;
    c_addr[0] = '0;
    c_data[0] = 8'h3C;
    avm_waitrequest = 1'b1;
    ch_write[0] = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      if (avm_write) begin
        wcnt++;
        last_w = cyc;
        tests++;
        if (avm_address !== '0 || avm_writedata !== 8'h3C) begin
          fails++; $display("FAIL ww_stable addr=%h data=%h exp=0/3c", avm_address, avm_writedata);
        end
        avm_waitrequest = (wcnt < 4);
      end
      if (ch_waitrequest[0] === 1'b0) begin
        acks++;
        ack_cyc = cyc;
      end
    end
    avm_waitrequest = 1'b0;
    tests++; if (wcnt != 4) begin fails++; $display("FAIL ww_write_cycles got=%0d exp=4", wcnt); end
    tests++; if (acks != 1) begin fails++; $display("FAIL ww_acks got=%0d exp=1", acks); end
    tests++; if (ack_cyc != last_w + 1) begin fails++; $display("FAIL ww_ack_cycle got=%0d exp=%0d", ack_cyc, last_w + 1); end
  endtask

  task automatic test_all_four();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      c_addr[i] = CAW'($urandom);
      c_data[i] = DW'($urandom);
    end
    ch_read  = 4'b0101;
    ch_write = 4'b1010;
    avm_waitrequest = 1'b0;
    served.delete();
    repeat (14) begin
      avm_readdata = DW'($urandom);
      step();
    end
    tests++;
    if (served.size() != 4) begin
      fails++; $display("FAIL all4_count got=%0d exp=4", served.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (served[i] != i) begin fails++; $display("FAIL all4_order[%0d] got=%0d exp=%0d", i, served[i], i); end
      end
    end
  endtask

  task automatic test_alternate();
    served.delete();
    c_addr[2] = 18'h00200; c_addr[3] = 18'h00300; c_data[3] = 8'h77;
    avm_waitrequest = 1'b0;
    repeat (12) begin
      ch_read[2]  = 1'b1;
      ch_write[3] = 1'b1;
      avm_readdata = DW'($urandom);
      step();
    end
    ch_read[2]  = 1'b0;
    ch_write[3] = 1'b0;
    repeat (4) step();
    tests++;
    if (served.size() < 4) begin
      fails++; $display("FAIL alt_count got=%0d exp>=4", served.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (served[i] != ((i % 2 == 0) ? 2 : 3)) begin
          fails++; $display("FAIL alt_order[%0d] got=%0d exp=%0d", i, served[i], (i % 2 == 0) ? 2 : 3);
        end
      end
    end
  endtask

  task automatic test_read_write_both();
    int wr_c = 0, rd_c = 0, rdv_c = 0;
    served.delete();
    c_addr[0] = 18'h00123;
    c_data[0] = 8'h5A;
    avm_waitrequest = 1'b0;
    ch_read[0]  = 1'b1;
    ch_write[0] = 1'b1;
    repeat (6) begin
      step();
      if (avm_write) wr_c++;
      if (avm_read) rd_c++;
      if (ch_readdatavalid != 0) rdv_c++;
    end
    tests++; if (wr_c != 1) begin fails++; $display("FAIL rw_writes got=%0d exp=1", wr_c); end
    tests++; if (rd_c != 0) begin fails++; $display("FAIL rw_reads got=%0d exp=0", rd_c); end
    tests++; if (rdv_c != 0) begin fails++; $display("FAIL rw_rdv got=%0d exp=0", rdv_c); end
    tests++; if (served.size() != 1) begin fails++; $display("FAIL rw_count got=%0d exp=1", served.size()); end
  endtask

  task automatic test_reset_mid();
    served.delete();
    c_addr[0] = 18'h00001;
    c_addr[1] = 18'h00042;
    avm_waitrequest = 1'b1;
    ch_read[1] = 1'b1;
    step();
    tests++; if (avm_read !== 1'b1) begin fails++; $display("FAIL rm_read_before got=%b exp=1", avm_read); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (avm_read !== 1'b0 || avm_write !== 1'b0) begin fails++; $display("FAIL rm_rw_after got=%b%b exp=00", avm_read, avm_write); end
    tests++; if (ch_waitrequest !== '1) begin fails++; $display("FAIL rm_waitreq got=%b exp=1111", ch_waitrequest); end
    tests++; if (served.size() != 0) begin fails++; $display("FAIL rm_no_ack got=%0d exp=0", served.size()); end
    ch_read[0] = 1'b1;
    avm_waitrequest = 1'b0;
    repeat (8) step();
    tests++;
    if (served.size() != 2 || served[0] != 0 || served[1] != 1) begin
      fails++; $display("FAIL rm_order size=%0d first=%0d exp=2 transactions 0 then 1",
                        served.size(), (served.size() > 0) ? served[0] : -1);
    end
  endtask

  task automatic test_random();
    int op;
    served.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!(ch_read[i] | ch_write[i]) && $urandom_range(0, 2) == 0) begin
          op = int'($urandom_range(0, 2));
          c_addr[i]   = CAW'($urandom);
          c_data[i]   = DW'($urandom);
          ch_read[i]  = (op != 1);
          ch_write[i] = (op != 0);
        end
      end
      avm_waitrequest = ($urandom_range(0, 4) < 2);
      avm_readdata    = DW'($urandom);
      step();
    end
    tests++;
    if (served.size() < 40) begin
      fails++; $display("FAIL rand_progress got=%0d exp>=40", served.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    ch_read = '0;
    ch_write = '0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    for (int i = 0; i < NCH; i++) begin
      c_addr[i] = '0;
      c_data[i] = '0;
    end
    model_reset();
    test_reset();
    test_single_read();
    test_write_wait();
    test_all_four();
    test_alternate();
    test_read_write_both();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
